// File: rtl/dpram_be_if.sv
// rtl/dpram_be_if.sv - write, read and clear bus of the byte-lane dual-port RAM
interface dpram_be_if #(
  parameter int dwidth     = 16,
  parameter int addr_width = 10,
  parameter int lane_width = 8
);
  localparam int nlanes = dwidth / lane_width;

  logic [addr_width-1:0] raddr;
  logic                  re;
  logic [addr_width-1:0] waddr;
  logic [dwidth-1:0]     wdata;
  logic                  we;
  logic [nlanes-1:0]     wbe;
  logic                  clear;
  logic                  busy;
  logic [dwidth-1:0]     rdata;
  logic                  rvalid;

  modport master (
    output raddr, re, waddr, wdata, we, wbe, clear,
    input  busy, rdata, rvalid
  );

  modport slave (
    input  raddr, re, waddr, wdata, we, wbe, clear,
    output busy, rdata, rvalid
  );
endinterface

// File: rtl/dpram_be.sv
// rtl/dpram_be.sv - dual-port RAM with lane write enables, read-during-write merge and clear sequencer
module dpram_be #(
  parameter int               dwidth         = 16,
  parameter int               addr_width     = 10,
  parameter int               lane_width     = 8,
  parameter int               rdw_mode       = 0,
  parameter int               out_reg        = 0,
  parameter int               clear_on_reset = 1,
  parameter logic [dwidth-1:0] clear_value   = '0
) (
  input  logic     clk,
  input  logic     reset_n,
  dpram_be_if.slave bus
);
  localparam int nlanes = dwidth / lane_width;
  localparam int depth  = 1 << addr_width;

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [addr_width-1:0] last_addr = {addr_width{1'b1}};

  logic [0:0]            state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic                  rv1_q, rv1_d;
  logic                  rv2_q, rv2_d;
  logic                  col_q, col_d;
  logic [dwidth-1:0]     wdata_q, wdata_d;
  logic [nlanes-1:0]     wbe_q, wbe_d;
  logic [dwidth-1:0]     rdata_q, rdata_d;

  logic                  busy;
  logic                  rd_en;
  logic                  user_we;
  logic [nlanes-1:0]     mem_wbe;
  logic [addr_width-1:0] mem_waddr;
  logic [dwidth-1:0]     mem_wdata;
  logic [dwidth-1:0]     mem_rd_q;
  logic [dwidth-1:0]     merged;

  logic [dwidth-1:0] mem [0:depth-1];

  assign busy    = (state_q == ST_CLEAR);
  assign rd_en   = bus.re & ~busy;
  assign user_we = bus.we & ~busy;

  // The clear sequencer borrows the write port; nothing lands while reset is held.
  always_comb begin
    mem_wbe   = '0;
    mem_waddr = bus.waddr;
    mem_wdata = bus.wdata;
    if (reset_n) begin
      if (busy) begin
        mem_wbe   = '1;
        mem_waddr = cnt_q;
        mem_wdata = clear_value;
      end else if (user_we) begin
        mem_wbe   = bus.wbe;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < nlanes; i++) begin
      if (mem_wbe[i]) begin
        mem[mem_waddr][i*lane_width +: lane_width] <= mem_wdata[i*lane_width +: lane_width];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_rd_q <= '0;
    end else if (rd_en) begin
      mem_rd_q <= mem[bus.raddr];
    end
  end

  // Array read returns old data; new-data lanes are patched in from the registered write.
  always_comb begin
    merged = mem_rd_q;
    for (int i = 0; i < nlanes; i++) begin
      if ((rdw_mode != 0) && col_q && wbe_q[i]) begin
        merged[i*lane_width +: lane_width] = wdata_q[i*lane_width +: lane_width];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == last_addr) begin
        state_d = ST_READY;
      end
    end else if (bus.clear) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end

    rv1_d   = rd_en;
    rv2_d   = rv1_q;
    col_d   = col_q;
    wdata_d = wdata_q;
    wbe_d   = wbe_q;
    if (rd_en) begin
      col_d   = user_we && (bus.raddr == bus.waddr);
      wdata_d = bus.wdata;
      wbe_d   = bus.wbe;
    end

    rdata_d = rdata_q;
    if (rv1_q) begin
      rdata_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= (clear_on_reset != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
      rv1_q   <= 1'b0;
      rv2_q   <= 1'b0;
      col_q   <= 1'b0;
      wdata_q <= '0;
      wbe_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv1_q   <= rv1_d;
      rv2_q   <= rv2_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
      wbe_q   <= wbe_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.busy   = busy;
  assign bus.rdata  = (out_reg != 0) ? rdata_q : merged;
  assign bus.rvalid = (out_reg != 0) ? rv2_q : rv1_q;
endmodule

// File: tb/tb_dpram_be.sv
// tb/tb_dpram_be.sv - self-checking bench for dpram_be, two configurations driven in lockstep
module tb_dpram_be;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int LW    = 8;
  localparam int NL    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          re, we, clr;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] wdata;
  logic [NL-1:0] wbe;

  dpram_be_if #(.dwidth(DW), .addr_width(AW), .lane_width(LW)) ifa ();
  dpram_be_if #(.dwidth(DW), .addr_width(AW), .lane_width(LW)) ifb ();

  assign ifa.re = re;  assign ifa.raddr = raddr;  assign ifa.we = we;  assign ifa.waddr = waddr;
  assign ifa.wdata = wdata;  assign ifa.wbe = wbe;  assign ifa.clear = clr;
  assign ifb.re = re;  assign ifb.raddr = raddr;  assign ifb.we = we;  assign ifb.waddr = waddr;
  assign ifb.wdata = wdata;  assign ifb.wbe = wbe;  assign ifb.clear = clr;

  dpram_be #(.dwidth(DW), .addr_width(AW), .lane_width(LW), .rdw_mode(0), .out_reg(0),
             .clear_on_reset(1), .clear_value(16'h0000))
    dut_a (.clk(clk), .reset_n(rst_n), .bus(ifa));

  dpram_be #(.dwidth(DW), .addr_width(AW), .lane_width(LW), .rdw_mode(1), .out_reg(1),
             .clear_on_reset(0), .clear_value(16'h5A5A))
    dut_b (.clk(clk), .reset_n(rst_n), .bus(ifb));

  int            lat  [2];
  bit            rdw  [2];
  bit            cor  [2];
  logic [DW-1:0] cv   [2];
  logic [DW-1:0] mmem [2][DEPTH];
  int            brem [2];
  int            cptr [2];
  bit            res_v [2][4];
  logic [DW-1:0] res_d [2][4];
  bit            exp_v [2];
  logic [DW-1:0] exp_d [2];
  int            ecount;
  int            n_chk;
  int            n_fail;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_edge(input int k);
    logic [DW-1:0] val;
    int s;
    if (!rst_n) begin
      brem[k] = cor[k] ? DEPTH : 0;
      cptr[k] = 0;
      exp_v[k] = 1'b0;
      exp_d[k] = '0;
      for (int j = 0; j < 4; j++) res_v[k][j] = 1'b0;
      return;
    end
    if (brem[k] > 0) begin
      mmem[k][cptr[k]] = cv[k];
      cptr[k]++;
      brem[k]--;
    end else begin
      if (clr) begin
        brem[k] = DEPTH;
        cptr[k] = 0;
      end
      if (re) begin
        val = mmem[k][raddr];
        if (rdw[k] && we && (waddr == raddr))
          for (int i = 0; i < NL; i++)
            if (wbe[i]) val[i*LW +: LW] = wdata[i*LW +: LW];
        s = (ecount + lat[k] - 1) % 4;
        res_v[k][s] = 1'b1;
        res_d[k][s] = val;
      end
      if (we)
        for (int i = 0; i < NL; i++)
          if (wbe[i]) mmem[k][waddr][i*LW +: LW] = wdata[i*LW +: LW];
    end
    s = ecount % 4;
    if (res_v[k][s]) begin
      exp_v[k] = 1'b1;
      exp_d[k] = res_d[k][s];
      res_v[k][s] = 1'b0;
    end else begin
      exp_v[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    ecount++;
    model_edge(0);
    model_edge(1);
    #1;
    chk("cyc_busy_a",   DW'(ifa.busy),   DW'(brem[0] > 0));
    chk("cyc_rvalid_a", DW'(ifa.rvalid), DW'(exp_v[0]));
    chk("cyc_rdata_a",  ifa.rdata,       exp_d[0]);
    chk("cyc_busy_b",   DW'(ifb.busy),   DW'(brem[1] > 0));
    chk("cyc_rvalid_b", DW'(ifb.rvalid), DW'(exp_v[1]));
    chk("cyc_rdata_b",  ifb.rdata,       exp_d[1]);
  endtask

  task automatic idle();
    re = 1'b0; we = 1'b0; clr = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NL-1:0] be;
    logic          re;
    logic [AW-1:0] ra;
    logic          chk;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
  } vec_t;

  vec_t tbl [6];
  logic [DW-1:0] t4_d [5];
  logic          t4_av [5];
  logic          t4_bv [5];
  int na, nb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lat = '{1, 2};  rdw = '{1'b0, 1'b1};  cor = '{1'b1, 1'b0};  cv = '{16'h0000, 16'h5A5A};
    n_chk = 0; n_fail = 0; ecount = 0;
    for (int k = 0; k < 2; k++) begin
      brem[k] = 0; cptr[k] = 0; exp_v[k] = 1'b0; exp_d[k] = '0;
      for (int j = 0; j < 4; j++) res_v[k][j] = 1'b0;
      for (int a = 0; a < DEPTH; a++) mmem[k][a] = '0;
    end
    tbl[0] = '{1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 4'd3, 16'h1200, 2'b10, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'h12CD, 16'h12CD};
    tbl[3] = '{1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 4'd5, 16'h2222, 2'b01, 1'b1, 4'd5, 1'b1, 16'h1111, 16'h1122};
    tbl[5] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 16'h1122, 16'h1122};

    rst_n = 1'b0; idle(); raddr = '0; waddr = '0; wdata = '0; wbe = '0;
    repeat (3) step();

    // auto-clear on A after reset; B started by the clear pulse (A ignores it while busy)
    rst_n = 1'b1;
    na = ifa.busy ? 1 : 0; nb = 0;
    clr = 1'b1; step(); clr = 1'b0;
    if (ifa.busy) na++;
    if (ifb.busy) nb++;
    for (int i = 0; i < 40 && (ifa.busy || ifb.busy); i++) begin
      step();
      if (ifa.busy) na++;
      if (ifb.busy) nb++;
    end
    chk("t1_busy_cycles_a", DW'(na), DW'(DEPTH));
    chk("t1_busy_cycles_b", DW'(nb), DW'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      re = 1'b1; raddr = AW'(a);
      step();
      chk("t1_read_a", ifa.rdata, 16'h0000);
    end
    idle(); step(); step();

    for (int v = 0; v < 6; v++) begin
      we = tbl[v].we; waddr = tbl[v].wa; wdata = tbl[v].wd; wbe = tbl[v].be;
      re = tbl[v].re; raddr = tbl[v].ra;
      step();
      idle();
      if (tbl[v].chk) chk("tbl_rdata_a", ifa.rdata, tbl[v].ea);
      step();
      if (tbl[v].chk) chk("tbl_rdata_b", ifb.rdata, tbl[v].eb);
    end

    // back-to-back reads through the latency-1 and latency-2 paths
    for (int a = 0; a < 3; a++) begin
      we = 1'b1; wbe = 2'b11; waddr = AW'(7 + a); wdata = DW'(16'h000A + a);
      step();
    end
    idle();
    t4_d  = '{16'h000A, 16'h000B, 16'h000C, 16'h000C, 16'h000C};
    t4_av = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t4_bv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      re = (c < 3); raddr = AW'(7 + c);
      step();
      chk("t4_rvalid_a", DW'(ifa.rvalid), DW'(t4_av[c]));
      chk("t4_rvalid_b", DW'(ifb.rvalid), DW'(t4_bv[c]));
      if (c < 3) chk("t4_rdata_a", ifa.rdata, t4_d[c]);
      if (c > 0) chk("t4_rdata_b", ifb.rdata, t4_d[c-1 < 3 ? c-1 : 2]);
    end
    idle();

    // second clear pulse and user traffic while busy must be ignored
    clr = 1'b1; step(); clr = 1'b0;
    na = ifa.busy ? 1 : 0; nb = ifb.busy ? 1 : 0;
    for (int i = 0; i < 40 && (ifa.busy || ifb.busy); i++) begin
      re = 1'b1; we = 1'b1; wbe = 2'b11;
      raddr = AW'($urandom); waddr = AW'($urandom); wdata = DW'($urandom);
      clr = (i == 5);
      step();
      if (ifa.busy) na++;
      if (ifb.busy) nb++;
    end
    idle();
    chk("t5_busy_cycles_a", DW'(na), DW'(DEPTH));
    chk("t5_busy_cycles_b", DW'(nb), DW'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      re = 1'b1; raddr = AW'(a);
      step();
      chk("t5_read_a", ifa.rdata, 16'h0000);
    end
    idle(); step(); step();
    chk("t5_read_b", ifb.rdata, 16'h5A5A);

    // reset partway into a clear
    we = 1'b1; wbe = 2'b11; waddr = 4'd3; wdata = 16'hBEEF; step();
    idle(); re = 1'b1; raddr = 4'd3; step(); idle(); step();
    chk("t6_pre_rdata_a", ifa.rdata, 16'hBEEF);
    clr = 1'b1; step(); clr = 1'b0;
    repeat (7) step();
    rst_n = 1'b0; step();
    chk("t6_rst_rdata_a",  ifa.rdata, 16'h0000);
    chk("t6_rst_rvalid_a", DW'(ifa.rvalid), 16'h0000);
    chk("t6_rst_rdata_b",  ifb.rdata, 16'h0000);
    rst_n = 1'b1;
    na = ifa.busy ? 1 : 0; nb = ifb.busy ? 1 : 0;
    for (int i = 0; i < 40 && (ifa.busy || ifb.busy); i++) begin
      step();
      if (ifa.busy) na++;
      if (ifb.busy) nb++;
    end
    chk("t6_busy_cycles_a", DW'(na), DW'(DEPTH));
    chk("t6_busy_cycles_b", DW'(nb), 16'd0);

    for (int i = 0; i < 600; i++) begin
      re = 1'($urandom); we = 1'($urandom); wbe = NL'($urandom);
      waddr = AW'($urandom); wdata = DW'($urandom);
      raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
      clr = ($urandom_range(0, 63) == 0);
      step();
    end
    idle(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dpram_be.md
Name: dpram_be

Overview:
Parametrised dual-port block RAM, one write port and one read port, for framebuffer and game-state storage. Adds byte-lane write enables, a selectable read-during-write policy, an optional output pipeline register, a read-valid flag, and a hardware clear sequencer. The sequencer initialises every word after reset or on request. The memory array stays inferable as BRAM; all added logic sits outside the array.

Parameters:
dwidth, 16, data word width in bits; must be an integer multiple of lane_width
addr_width, 10, address width; depth = 2**addr_width words
lane_width, 8, bits per write-enable lane; nlanes = dwidth/lane_width
rdw_mode, 0, same-address read-during-write result: 0 = old data, 1 = new data (per-lane merge)
out_reg, 0, 0 = read latency 1; 1 = extra output register, read latency 2
clear_on_reset, 1, 1 = run clear sequence automatically after reset; 0 = only on clear request
clear_value, 0, dwidth-wide word written to every address during a clear

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_n  in  1  synchronous active-low reset
raddr  in  addr_width  read address
re  in  1  read enable
waddr  in  addr_width  write address
wdata  in  dwidth  write data
we  in  1  write enable
wbe  in  nlanes  lane write enables; lane i covers wdata[i*lane_width +: lane_width]
clear  in  1  one-cycle pulse; starts a clear sequence when idle
busy  out  1  clear sequence in progress
rdata  out  dwidth  read data
rvalid  out  1  rdata updated this cycle with a new read result

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - rdata=0, rvalid=0, pipeline and bypass registers cleared.
  - Clear FSM goes to CLEAR with counter=0 if clear_on_reset=1, otherwise to READY with busy=0.
  - Array contents are not reset directly.
- Clear FSM states:
  - READY: busy=0.
  - CLEAR: busy=1. Each cycle writes clear_value (all lanes) to counter, then increments counter. After writing address depth-1, moves to READY on the next edge.
  - A full clear takes exactly depth cycles of busy=1.
- clear pulse:
  - In READY, moves to CLEAR with counter=0 on the next edge.
  - In CLEAR, ignored; no restart.
  - Reset asserted mid-clear aborts it and restarts per clear_on_reset.
- While busy=1:
  - User we and re are ignored: no user writes, no rvalid.
  - rdata holds its last value.
- Write (READY, we=1):
  - Each lane i with wbe[i]=1 is written at waddr; lanes with wbe[i]=0 keep their contents.
  - we=1 with wbe=0 is a no-op.
- Read (READY, re=1):
  - out_reg=0: rdata = mem[raddr] and rvalid=1 on edge N+1.
  - out_reg=1: the same result and rvalid=1 on edge N+2.
  - rvalid is 1 for exactly one cycle per accepted read.
  - Back-to-back reads give one result per cycle.
  - With no read, rdata holds and rvalid=0.
- Read-during-write (same cycle, re=1, we=1, raddr==waddr):
  - rdw_mode=0: returns the pre-write word.
  - rdw_mode=1: each lane with wbe set returns wdata's lane; other lanes return the old lane.
  - Implement by registering wdata, wbe and a collision flag, then merging at the array output.
  - Different addresses: no interaction.
- Addresses are full-range; no wrap logic needed. Address depth-1 must be reachable by both ports and by the clear counter.
- The clear counter is addr_width+1 bits wide, or uses a terminal-count flag, so depth-1 is the last address cleared with no early exit.

Test Plan:
1. clear_on_reset=1, addr_width=4: release reset_n, then read addresses 0..15. Required: busy=1 for exactly 16 cycles, and every read returns 0x0000 with rvalid one cycle after re.
2. Write 0xABCD to addr 3 with wbe=11, then 0x1200 with wbe=10, then read addr 3. Required: rdata=0x12CD.
3. rdw_mode=0: mem[5]=0x1111, then the same cycle we=1 wdata=0x2222 wbe=01 re=1 raddr=5. Required: rdata=0x1111, and a later read returns 0x1122. Repeat with rdw_mode=1: the collision read returns 0x1122.
4. out_reg=1: re pulses on 3 consecutive cycles to addresses holding 0xA, 0xB, 0xC. Required: rvalid high on edges N+2..N+4 with rdata 0xA, 0xB, 0xC in order.
5. In READY after writes, pulse clear, pulse clear again mid-sequence, and assert we/re while busy. Required: busy lasts exactly depth cycles (no restart), no writes land, no rvalid, and all words read as clear_value afterwards.
6. Assert reset_n=0 at counter=7 during a clear. Required: the sequence restarts at 0, busy lasts a full depth cycles after release, and rdata=0 and rvalid=0 immediately after reset.
